// File: rtl/rcv_block_fifo.sv
// Parametrised serial receiver with glitch-filtered start and a receive FIFO.
// Optional even-parity checking is enabled by defining RCV_PARITY_EN.
module rcv_block_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  input  logic                          data_read,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun_error,
  output logic                          framing_error,
  output logic                          parity_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RCV_PARITY_EN
    PARITY,
`endif
    STOP,
    COMMIT
  } state_t;

  state_t state, nstate;

  logic                 sync1, sync2, sync_d;
  logic                 fall;
  logic [TW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 stop_bit;
  logic                 half_tick, bit_tick, tick;
  logic                 par_bad, frame_ok, commit;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr, count;
  logic                 empty, full;
  logic                 do_pop, push_req, do_push, ovr_set;

  assign fall      = sync_d & ~sync2;
  assign half_tick = (clk_cnt == HALF_LAST);
  assign bit_tick  = (clk_cnt == BIT_LAST);
  assign tick      = (state == START) ? half_tick : bit_tick;
  assign commit    = (state == COMMIT);

  // Two-flop synchroniser plus delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= serial_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic; a high mid-start sample is treated as a glitch.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:   if (fall) nstate = START;
      START:  if (half_tick) nstate = sync2 ? IDLE : DATA;
      DATA: begin
        if (bit_tick && bit_cnt == DATA_LAST)
`ifdef RCV_PARITY_EN
          nstate = PARITY;
`else
          nstate = STOP;
`endif
      end
`ifdef RCV_PARITY_EN
      PARITY: if (bit_tick) nstate = STOP;
`endif
      STOP:   if (bit_tick) nstate = COMMIT;
      COMMIT: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

`ifdef RCV_PARITY_EN
  logic par_bit;

  // Captures the parity bit mid-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            par_bit <= 1'b0;
    else if (state == PARITY && bit_tick) par_bit <= sync2;
  end

  assign par_bad = par_bit ^ (^shift_reg);
`else
  assign par_bad = 1'b0;
`endif

  assign frame_ok = stop_bit & ~par_bad;

  // Bit timing, LSB-first shift register and stop-bit capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      stop_bit  <= 1'b1;
    end else begin
      if (state == IDLE || commit || tick) clk_cnt <= '0;
      else                                 clk_cnt <= clk_cnt + 1'b1;
      if (state == IDLE) bit_cnt <= '0;
      if (state == DATA && bit_tick) begin
        shift_reg <= {sync2, shift_reg[DATA_BITS-1:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (state == STOP && bit_tick) stop_bit <= sync2;
    end
  end

  // Per-frame status, refreshed at every commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      framing_error <= 1'b0;
    end else if (commit) begin
      framing_error <= ~stop_bit;
    end
  end

`ifdef RCV_PARITY_EN
  // Parity status of the last committed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         parity_error <= 1'b0;
    else if (commit) parity_error <= par_bad;
  end
`else
  assign parity_error = 1'b0;
`endif

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = data_read & ~empty;
  assign push_req = commit & frame_ok;
  assign do_push  = push_req & (~full | do_pop);
  assign ovr_set  = push_req & full & ~do_pop;

  // FIFO storage; contents are only visible through the non-empty gate.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shift_reg;
  end

  // Pointers with an extra wrap bit and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      overrun_error <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (ovr_set)     overrun_error <= 1'b1;
      else if (do_pop) overrun_error <= 1'b0;
    end
  end

  assign rx_data    = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign data_ready = ~empty;
  assign fifo_count = count;

endmodule

// File: tb/tb_rcv_block_fifo.sv
// Randomised self-checking bench for rcv_block_fifo.
// Reference model is a queue of frames plus flag bits updated per frame.
module tb_rcv_block_fifo;

  localparam int DB    = 8;
  localparam int CPB   = 10;
  localparam int DEPTH = 4;
`ifdef RCV_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Cycle index (from the start-bit drive) whose edge is the COMMIT edge,
  // from the nominal latency (DB+PB+1.5)*CPB+3.
  localparam int COMMIT_AT = (DB + PB + 1) * CPB + CPB / 2 + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          serial_in = 1'b1;
  logic          data_read = 1'b0;
  logic [DB-1:0] rx_data;
  logic          data_ready;
  logic [2:0]    fifo_count;
  logic          overrun_error;
  logic          framing_error;
  logic          parity_error;

  rcv_block_fifo #(
    .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .data_read(data_read),
    .rx_data(rx_data), .data_ready(data_ready), .fifo_count(fifo_count),
    .overrun_error(overrun_error), .framing_error(framing_error),
    .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  logic [DB-1:0] q[$];
  bit m_ovr, m_ferr, m_perr;
  int errs = 0;
  int checks = 0;

  function automatic logic [DB-1:0] exp_head();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  // Drives one frame; optionally pops at cycle pop_at or resets at abort_at.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop,
                            input logic par, input int pop_at,
                            input int abort_at);
    logic bits[$];
    int cyc = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
`ifdef RCV_PARITY_EN
    bits.push_back(par);
`else
    if (par === 1'bz) bits.push_back(1'b1);
`endif
    bits.push_back(stop);
    foreach (bits[k]) begin
      repeat (CPB) begin
        if (cyc == abort_at) begin
          rst = 1'b1;
          serial_in = 1'b1;
          data_read = 1'b0;
          @(posedge clk); #1;
          rst = 1'b0;
          return;
        end
        serial_in = bits[k];
        data_read = (cyc == pop_at);
        @(posedge clk); #1;
        cyc++;
      end
    end
    data_read = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic model_commit(input logic [DB-1:0] d, input logic stop,
                              input logic par, input bit popped);
    bit pop_ok, setv, ok;
    setv = 0;
    m_ferr = !stop;
    m_perr = (PB != 0) && (par != ^d);
    ok = stop && !m_perr;
    pop_ok = popped && q.size() != 0;
    if (pop_ok) void'(q.pop_front());
    if (ok) begin
      if (q.size() < DEPTH) q.push_back(d);
      else setv = 1;
    end
    if (setv) m_ovr = 1;
    else if (pop_ok) m_ovr = 0;
  endtask

  task automatic frame(input logic [DB-1:0] d, input logic stop);
    send_frame(d, stop, ^d, -1, -1);
    model_commit(d, stop, ^d, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_read();
    data_read = 1'b1;
    @(posedge clk); #1;
    data_read = 1'b0;
    if (q.size() != 0) begin
      void'(q.pop_front());
      m_ovr = 0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_data, data_ready, fifo_count, overrun_error,
         framing_error, parity_error} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got rx=%h rdy=%b cnt=%0d ovr=%b fe=%b pe=%b exp all 0",
               rx_data, data_ready, fifo_count, overrun_error,
               framing_error, parity_error);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fifo_count !== 3'd0 || data_ready !== 1'b0) begin
      errs++;
      $display("FAIL post_reset got cnt=%0d rdy=%b exp 0 0",
               fifo_count, data_ready);
    end
  endtask

  task automatic test_clean_frame();
    frame(8'hA5, 1'b1);
    checks++;
    if (data_ready !== 1'b1 || rx_data !== 8'hA5 || fifo_count !== 3'd1) begin
      errs++;
      $display("FAIL clean_frame got rdy=%b rx=%h cnt=%0d exp 1 a5 1",
               data_ready, rx_data, fifo_count);
    end
    do_read();
    checks++;
    if (data_ready !== 1'b0 || rx_data !== 8'h00 || fifo_count !== 3'd0) begin
      errs++;
      $display("FAIL clean_read got rdy=%b rx=%h cnt=%0d exp 0 00 0",
               data_ready, rx_data, fifo_count);
    end
    do_read();
    checks++;
    if (fifo_count !== 3'd0 || rx_data !== 8'h00) begin
      errs++;
      $display("FAIL empty_read got cnt=%0d rx=%h exp 0 00",
               fifo_count, rx_data);
    end
  endtask

  task automatic test_glitch();
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    checks++;
    if (fifo_count !== 3'd0 || framing_error !== 1'b0 ||
        overrun_error !== 1'b0 || parity_error !== 1'b0) begin
      errs++;
      $display("FAIL glitch got cnt=%0d fe=%b ovr=%b pe=%b exp 0 0 0 0",
               fifo_count, framing_error, overrun_error, parity_error);
    end
    frame(8'h5A, 1'b1);
    checks++;
    if (rx_data !== 8'h5A || fifo_count !== 3'd1) begin
      errs++;
      $display("FAIL glitch_then_frame got rx=%h cnt=%0d exp 5a 1",
               rx_data, fifo_count);
    end
    do_read();
  endtask

  task automatic test_framing();
    frame(8'h3C, 1'b0);
    checks++;
    if (framing_error !== 1'b1 || fifo_count !== 3'd0) begin
      errs++;
      $display("FAIL framing_bad got fe=%b cnt=%0d exp 1 0",
               framing_error, fifo_count);
    end
    frame(8'h11, 1'b1);
    checks++;
    if (framing_error !== 1'b0 || rx_data !== 8'h11) begin
      errs++;
      $display("FAIL framing_clear got fe=%b rx=%h exp 0 11",
               framing_error, rx_data);
    end
    do_read();
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1);
    checks++;
    if (fifo_count !== 3'd4 || overrun_error !== 1'b1 || rx_data !== 8'h01) begin
      errs++;
      $display("FAIL overrun got cnt=%0d ovr=%b rx=%h exp 4 1 01",
               fifo_count, overrun_error, rx_data);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rx_data !== 8'(i)) begin
        errs++;
        $display("FAIL overrun_read%0d got %h exp %h", i, rx_data, 8'(i));
      end
      do_read();
      checks++;
      if (overrun_error !== 1'b0) begin
        errs++;
        $display("FAIL overrun_clear%0d got %b exp 0", i, overrun_error);
      end
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 1'b1);
    send_frame(8'h55, 1'b1, ^8'h55, COMMIT_AT - 1, -1);
    model_commit(8'h55, 1'b1, ^8'h55, 1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (fifo_count !== 3'd4 || overrun_error !== 1'b0 || rx_data !== 8'h11) begin
      errs++;
      $display("FAIL full_push_pop got cnt=%0d ovr=%b rx=%h exp 4 0 11",
               fifo_count, overrun_error, rx_data);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_data !== exp_head()) begin
        errs++;
        $display("FAIL full_drain%0d got %h exp %h", i, rx_data, exp_head());
      end
      do_read();
    end
  endtask

  task automatic test_reset_mid();
    frame(8'h33, 1'b1);
    send_frame(8'hC3, 1'b1, ^8'hC3, -1, 4 * CPB);
    q.delete();
    m_ovr = 0; m_ferr = 0; m_perr = 0;
    checks++;
    if ({rx_data, data_ready, fifo_count, overrun_error,
         framing_error, parity_error} !== '0) begin
      errs++;
      $display("FAIL mid_reset got rx=%h rdy=%b cnt=%0d ovr=%b fe=%b pe=%b exp all 0",
               rx_data, data_ready, fifo_count, overrun_error,
               framing_error, parity_error);
    end
    frame(8'h9E, 1'b1);
    checks++;
    if (rx_data !== 8'h9E || fifo_count !== 3'd1) begin
      errs++;
      $display("FAIL mid_reset_next got rx=%h cnt=%0d exp 9e 1",
               rx_data, fifo_count);
    end
    do_read();
  endtask

`ifdef RCV_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b1, -1, -1);
    model_commit(8'h07, 1'b1, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (parity_error !== 1'b0 || rx_data !== 8'h07 || fifo_count !== 3'd1) begin
      errs++;
      $display("FAIL parity_good got pe=%b rx=%h cnt=%0d exp 0 07 1",
               parity_error, rx_data, fifo_count);
    end
    send_frame(8'h07, 1'b1, 1'b0, -1, -1);
    model_commit(8'h07, 1'b1, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (parity_error !== 1'b1 || fifo_count !== 3'd1) begin
      errs++;
      $display("FAIL parity_bad got pe=%b cnt=%0d exp 1 1",
               parity_error, fifo_count);
    end
    do_read();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int op;
      logic [DB-1:0] d;
      logic par;
      d = DB'($urandom);
      par = ^d;
`ifdef RCV_PARITY_EN
      if ($urandom_range(0, 7) == 0) par = ~par;
`endif
      op = $urandom_range(0, 9);
      if (op < 5) begin
        send_frame(d, 1'b1, par, -1, -1);
        model_commit(d, 1'b1, par, 0);
      end else if (op == 5) begin
        send_frame(d, 1'b0, par, -1, -1);
        model_commit(d, 1'b0, par, 0);
      end else if (op < 9) begin
        do_read();
      end else begin
        send_frame(d, 1'b1, par, COMMIT_AT - 1, -1);
        model_commit(d, 1'b1, par, 1);
      end
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      checks++;
      if (rx_data !== exp_head() || fifo_count !== 3'(q.size()) ||
          data_ready !== (q.size() != 0) || overrun_error !== m_ovr ||
          framing_error !== m_ferr || parity_error !== m_perr) begin
        errs++;
        $display("FAIL random%0d op=%0d got rx=%h cnt=%0d rdy=%b ovr=%b fe=%b pe=%b exp rx=%h cnt=%0d ovr=%b fe=%b pe=%b",
                 n, op, rx_data, fifo_count, data_ready, overrun_error,
                 framing_error, parity_error, exp_head(), q.size(),
                 m_ovr, m_ferr, m_perr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_glitch();
    test_framing();
    test_overrun();
    test_full_push_pop();
    test_reset_mid();
`ifdef RCV_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rcv_block_fifo.md
Name: rcv_block_fifo

Overview:
- Parametrised serial receiver, successor to the fixed 8-bit single-buffer receiver.
- Generalises data width and bit period, and adds a power-of-two receive FIFO in place of the one-entry buffer.
- Adds glitch-rejecting start detection and optional parity checking.
- Sits between the synchronised serial line and the system-side consumer, which drains frames with a data_read pulse.

Parameters:
- DATA_BITS, 8, payload bits per frame, legal range 5..9, LSB first on the line.
- CLKS_PER_BIT, 10, clk cycles per serial bit, minimum 4.
- FIFO_DEPTH, 4, receive FIFO entries, power of two, minimum 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- serial_in  in  1  raw serial line, idle high.
- data_read  in  1  one-cycle pop strobe for the FIFO head.
- rx_data  out  DATA_BITS  FIFO head entry; 0 when the FIFO is empty.
- data_ready  out  1  FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overrun_error  out  1  sticky; a completed frame was dropped because the FIFO was full.
- framing_error  out  1  status of the last completed frame: stop bit sampled low.
- parity_error  out  1  status of the last completed frame: parity mismatch (see Optional Feature).

Behaviour:
- Reset: all outputs are 0, FIFO is empty, pointers are 0, FSM is in IDLE, synchroniser flops are set to 1.
- Input path: serial_in passes through a 2-flop synchroniser. A falling edge is detected between the synchronised value and its one-cycle-delayed copy.
- FSM states and transitions:
  - IDLE -> START on a detected falling edge; the bit counter is cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then sample.
    - Sample 1 -> IDLE. Glitch rejected, no status change.
    - Sample 0 -> DATA.
  - DATA: sample every CLKS_PER_BIT cycles into a shift register, LSB first. After DATA_BITS samples -> PARITY if enabled, otherwise -> STOP.
  - PARITY: one sample, compared against the even parity of the data bits.
  - STOP: one sample, then -> COMMIT.
  - COMMIT (one cycle):
    - Update framing_error and parity_error for this frame.
    - If the frame is clean, push it to the FIFO.
    - -> IDLE.
- Frames with a framing or parity error are never pushed. framing_error and parity_error hold their value until the next COMMIT, where they are cleared or set again.
- Latency: the push occurs in COMMIT. data_ready rises in the cycle after COMMIT, about (DATA_BITS+1.5)*CLKS_PER_BIT+3 cycles after the start edge.
- Pop: data_read while data_ready advances the read pointer; the new head appears on rx_data in the next cycle. data_read while empty is ignored.
- Full boundary:
  - Push while full with no simultaneous pop: drop the frame and set overrun_error. Existing entries are unchanged.
  - Push and pop in the same cycle while full: both take effect, fifo_count is unchanged, and overrun_error is not set.
- Empty boundary: simultaneous push and pop while empty performs the push only; the pop is ignored.
- overrun_error clears on the first accepted data_read after it was set; the same-cycle set condition wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_count = write_ptr - read_ptr using one extra wrap bit.
- A new start edge is ignored outside IDLE. Back-to-back frames may start on the cycle after COMMIT.
- rst asserted mid-frame: the frame is abandoned, the FIFO is emptied, and all flags are cleared immediately.

Optional Feature:
- Macro RCV_PARITY_EN.
- Defined: the frame carries one even-parity bit between the data bits and the stop bit. A mismatch sets parity_error at COMMIT and the frame is discarded.
- Undefined: the PARITY state is absent, frames are DATA_BITS+2 bits long, and parity_error is tied to 0.

Test Plan (DATA_BITS=8, CLKS_PER_BIT=10, FIFO_DEPTH=4, macro undefined unless stated):
- Clean frame 0xA5 with stop=1 -> data_ready=1, rx_data=0xA5, fifo_count=1. After data_read: data_ready=0, rx_data=0.
- Low pulse of 3 cycles on an idle line -> FSM returns to IDLE, fifo_count=0, no flags set.
- Frame 0x3C with stop=0 -> framing_error=1, fifo_count=0. Next clean frame 0x11 -> framing_error=0, rx_data=0x11.
- Five frames 0x01..0x05 with no reads -> fifo_count=4, overrun_error=1, rx_data=0x01. Four reads return 0x01..0x04; overrun_error clears after the first read.
- FIFO full, data_read asserted in the COMMIT cycle of frame 0x55 -> no overrun, fifo_count stays 4, 0x55 is read last.
- RCV_PARITY_EN defined:
  - Frame 0x07 with parity bit 1 -> accepted.
  - Frame 0x07 with parity bit 0 -> parity_error=1, not stored.
  - rst asserted mid-DATA -> all outputs 0, and a following clean frame 0x9E is received correctly.
